// File: rtl/rxbuf_pkg.sv
// Shared defaults and types for the RX receive buffer FIFO.
package rxbuf_pkg;

  localparam int RXBUF_WIDTH_DEF = 8;
  localparam int RXBUF_DEPTH_DEF = 4;
  localparam int RXBUF_CNT_W     = $clog2(RXBUF_DEPTH_DEF) + 1;

  typedef logic [RXBUF_CNT_W-1:0] rxbuf_count_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } rxbuf_occ_e;

endpackage

// File: rtl/rx_buffer_fifo_if.sv
// Handshake bundle between the RX channel / consumer and the receive buffer FIFO.
interface rx_buffer_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);

  logic [WIDTH-1:0]         rx_data;
  logic                     rx_new_data;
  logic                     rx_hold;
  logic                     rd_en;
  logic [WIDTH-1:0]         rd_data;
  logic                     rd_valid;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;

  modport master (
    output rx_data, rx_new_data, rd_en,
    input  rx_hold, rd_data, rd_valid, count, overflow
  );

  modport slave (
    input  rx_data, rx_new_data, rd_en,
    output rx_hold, rd_data, rd_valid, count, overflow
  );

endinterface

// File: rtl/rxbuf_ctrl.sv
// Pointer, occupancy, overflow and backpressure control for rx_buffer_fifo.
// Optional macro RXBUF_ALMOST_FULL_EN raises rx_hold one entry early.
import rxbuf_pkg::*;

module rxbuf_ctrl #(
  parameter  int DEPTH = RXBUF_DEPTH_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic          push_req,
  input  logic          pop_req,
  output logic          push_en,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          rx_hold,
  output logic          rd_valid
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, pop;
  rxbuf_occ_e    occ;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    occ        = OCC_PARTIAL;
    if (count_q == '0)           occ = OCC_EMPTY;
    else if (count_q == FULL_CNT) occ = OCC_FULL;

    pop        = pop_req && (occ != OCC_EMPTY);
    // A full buffer still accepts a word when the head leaves on the same edge.
    push       = push_req && ((occ != OCC_FULL) || pop);

    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    overflow_d = overflow_q || (push_req && !push);

    count_d    = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign push_en  = push;
  assign wr_ptr   = wr_ptr_q;
  assign rd_ptr   = rd_ptr_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign rd_valid = (count_q != '0);

`ifdef RXBUF_ALMOST_FULL_EN
  // One entry of slack covers the cycle the RX channel needs to see hold and stop.
  assign rx_hold = (count_q >= FULL_CNT - CW'(1));
`else
  assign rx_hold = (count_q == FULL_CNT);
`endif

endmodule

// File: rtl/rx_buffer_fifo.sv
// First-word fall-through receive buffer between the RX channel and a consumer.
// Optional macro RXBUF_ALMOST_FULL_EN (handled in rxbuf_ctrl) asserts rx_hold at DEPTH-1.
import rxbuf_pkg::*;

module rx_buffer_fifo #(
  parameter int WIDTH = RXBUF_WIDTH_DEF,
  parameter int DEPTH = RXBUF_DEPTH_DEF
) (
  input  logic          ACLK,
  input  logic          ARESET,
  rx_buffer_fifo_if.slave bus
);

  localparam int PW = $clog2(DEPTH);

  logic             push_en;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  rxbuf_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .push_req (bus.rx_new_data),
    .pop_req  (bus.rd_en),
    .push_en  (push_en),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (bus.count),
    .overflow (bus.overflow),
    .rx_hold  (bus.rx_hold),
    .rd_valid (bus.rd_valid)
  );

  // NOTE: storage has no reset; the cleared pointers and count already mark every entry invalid.
  always_ff @(posedge ACLK) begin
    if (push_en) mem[wr_ptr] <= bus.rx_data;
  end

  assign bus.rd_data = mem[rd_ptr];

endmodule

// File: tb/tb_rx_buffer_fifo.sv
// Randomized and directed bench for rx_buffer_fifo (WIDTH=8, DEPTH=4) against a queue model.
module tb_rx_buffer_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic ACLK;
  logic ARESET;

  rx_buffer_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  rx_buffer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  // Reference model: the buffered words in arrival order plus the sticky drop flag.
  logic [7:0] q[$];
  bit         ovf;
  logic [7:0] popped;
  logic [7:0] exp_pop;
  bit         did_pop;

  function automatic bit model_hold();
`ifdef RXBUF_ALMOST_FULL_EN
    return q.size() >= DEPTH - 1;
`else
    return q.size() == DEPTH;
`endif
  endfunction

  // One clock cycle of stimulus; called just after a rising edge, returns 1 ns after the next.
  task automatic step(input bit nd, input logic [7:0] d, input bit re);
    bit pop_ok, push_ok;
    pop_ok  = re && (q.size() != 0);
    push_ok = nd && ((q.size() < DEPTH) || pop_ok);
    did_pop = pop_ok;
    exp_pop = pop_ok ? q[0] : 8'h00;
    popped  = bus.rd_data;
    bus.rx_new_data = nd;
    bus.rx_data     = d;
    bus.rd_en       = re;
    @(posedge ACLK);
    #1;
    if (pop_ok) q.delete(0);
    if (push_ok) q.push_back(d);
    if (nd && !push_ok) ovf = 1'b1;
    bus.rx_new_data = 1'b0;
    bus.rd_en       = 1'b0;
    bus.rx_data     = 8'h00;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    bus.rx_new_data = 1'b0;
    bus.rd_en       = 1'b0;
    bus.rx_data     = 8'h00;
    q.delete();
    ovf = 1'b0;
    #12;
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    total++; if (bus.rx_hold !== 1'b0) begin bad++; $display("FAIL reset_rx_hold got=%b exp=0", bus.rx_hold); end
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, vals[i], 1'b0);
      if (i == 2) begin
`ifdef RXBUF_ALMOST_FULL_EN
        total++; if (bus.rx_hold !== 1'b1) begin bad++; $display("FAIL hold_at_3 got=%b exp=1", bus.rx_hold); end
`else
        total++; if (bus.rx_hold !== 1'b0) begin bad++; $display("FAIL hold_at_3 got=%b exp=0", bus.rx_hold); end
`endif
      end
    end
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", bus.count); end
    total++; if (bus.rx_hold !== 1'b1) begin bad++; $display("FAIL fill_rx_hold got=%b exp=1", bus.rx_hold); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++; if (popped !== vals[i]) begin bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, popped, vals[i]); end
    end
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", bus.count); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL drain_rd_valid got=%b exp=0", bus.rd_valid); end
    step(1'b0, 8'h00, 1'b1);
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL empty_pop_count got=%0d exp=0", bus.count); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) step(1'b1, 8'hB0 + 8'(i), 1'b0);
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_before got=%b exp=0", bus.overflow); end
    step(1'b1, 8'h5A, 1'b0);
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", bus.count); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++; if (popped !== 8'hB0 + 8'(i)) begin bad++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, popped, 8'hB0 + 8'(i)); end
    end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained_valid got=%b exp=0", bus.rd_valid); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
  endtask

  task automatic test_midstream_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
    total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL mid_pre_count got=%0d exp=3", bus.count); end
    #2 ARESET = 1'b1;
    #1;
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL mid_reset_count got=%0d exp=0", bus.count); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%b exp=0", bus.rd_valid); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL mid_reset_overflow got=%b exp=0", bus.overflow); end
    q.delete();
    ovf = 1'b0;
    #2 ARESET = 1'b0;
    @(posedge ACLK);
    #1;
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h12, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    total++; if (popped !== 8'h11) begin bad++; $display("FAIL mid_first_pop got=%h exp=11", popped); end
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp4 [4] = '{8'hD1, 8'hD2, 8'hD3, 8'h77};
    for (int i = 0; i < 4; i++) step(1'b1, 8'hD0 + 8'(i), 1'b0);
    step(1'b1, 8'h77, 1'b1);
    total++; if (popped !== 8'hD0) begin bad++; $display("FAIL sim_full_pop got=%h exp=d0", popped); end
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL sim_full_count got=%0d exp=4", bus.count); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL sim_full_ovf got=%b exp=0", bus.overflow); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++; if (popped !== exp4[i]) begin bad++; $display("FAIL sim_drain[%0d] got=%h exp=%h", i, popped, exp4[i]); end
    end
    step(1'b1, 8'h33, 1'b1);
    total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL sim_empty_count got=%0d exp=1", bus.count); end
    total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL sim_empty_valid got=%b exp=1", bus.rd_valid); end
    total++; if (bus.rd_data !== 8'h33) begin bad++; $display("FAIL sim_empty_data got=%h exp=33", bus.rd_data); end
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_wrap();
    step(1'b1, 8'hE0, 1'b0);
    step(1'b1, 8'hE1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(i), 1'b1);
      total++; if (popped !== exp_pop) begin bad++; $display("FAIL wrap_pop[%0d] got=%h exp=%h", i, popped, exp_pop); end
      total++; if (bus.count !== 3'd2) begin bad++; $display("FAIL wrap_count[%0d] got=%0d exp=2", i, bus.count); end
    end
    for (int i = 8; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b1);
      total++; if (popped !== 8'(i)) begin bad++; $display("FAIL wrap_tail got=%h exp=%h", popped, 8'(i)); end
    end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL wrap_ovf got=%b exp=0", bus.overflow); end
  endtask

  task automatic test_random();
    bit         nd, re;
    logic [7:0] d;
    for (int i = 0; i < 400; i++) begin
      nd = ($urandom_range(0, 99) < 55);
      re = ($urandom_range(0, 99) < 45);
      d  = 8'($urandom);
      step(nd, d, re);
      if (did_pop) begin
        total++; if (popped !== exp_pop) begin bad++; $display("FAIL rnd_pop[%0d] got=%h exp=%h", i, popped, exp_pop); end
      end
      total++; if (bus.count !== 3'(q.size())) begin bad++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, bus.count, q.size()); end
      total++; if (bus.rd_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, bus.rd_valid, q.size() != 0); end
      total++; if (bus.rx_hold !== model_hold()) begin bad++; $display("FAIL rnd_hold[%0d] got=%b exp=%b", i, bus.rx_hold, model_hold()); end
      total++; if (bus.overflow !== ovf) begin bad++; $display("FAIL rnd_ovf[%0d] got=%b exp=%b", i, bus.overflow, ovf); end
      if (q.size() != 0) begin
        total++; if (bus.rd_data !== q[0]) begin bad++; $display("FAIL rnd_head[%0d] got=%h exp=%h", i, bus.rd_data, q[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_midstream_reset();
    test_simultaneous();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_buffer_fifo.md
RX_BUFFER_FIFO -- requirements
Module: rx_buffer_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; SHALL match the connected RX_channel WIDTH.
REQ-002 Parameter DEPTH, default 4, entry count; SHALL be a power of two and >= 2.
REQ-003 ACLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 ARESET  input  1  reset, asynchronous and active-high.
REQ-005 rx_data  input  WIDTH  word delivered by RX_channel.
REQ-006 rx_new_data  input  1  one-cycle strobe that rx_data is valid and must be stored.
REQ-007 rx_hold  output  1  backpressure to RX_channel; high = do not deliver.
REQ-008 rd_en  input  1  consumer pop request.
REQ-009 rd_data  output  WIDTH  head entry, first-word fall-through.
REQ-010 rd_valid  output  1  high when rd_data holds a stored word (not empty).
REQ-011 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 overflow  output  1  sticky flag: a word was dropped.

Function
REQ-013 Push SHALL occur on a rising edge with rx_new_data=1 and (count<DEPTH, or count==DEPTH with a pop in the same cycle); rx_data is written at wr_ptr and wr_ptr increments.
REQ-014 Pop SHALL occur on a rising edge with rd_en=1 and rd_valid=1; rd_ptr increments; rd_en while empty SHALL be ignored with no state change.
REQ-015 Pointers SHALL wrap modulo DEPTH; count SHALL be +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-016 Occupancy states: EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH); transitions only by +/-1 per REQ-015.
REQ-017 rd_data SHALL be combinational from storage[rd_ptr]; a pushed word SHALL be visible on rd_data/rd_valid the cycle after its push edge (latency 1, no same-cycle bypass).
REQ-018 EMPTY with push and rd_en together: push accepted, pop ignored, count becomes 1.
REQ-019 FULL with push and pop together: both accepted, count stays DEPTH, oldest word leaves, new word enters.
REQ-020 rx_new_data while FULL without a pop: word dropped, storage/pointers unchanged, overflow set on that edge.
REQ-021 overflow SHALL remain 1 until ARESET.
REQ-022 rx_hold SHALL be combinational from count: 1 when count==DEPTH (see REQ-027).
REQ-023 rd_data while rd_valid=0 SHALL be don't-care; the bench SHALL not check it.

Reset
REQ-024 ARESET=1 SHALL immediately and asynchronously clear wr_ptr, rd_ptr, count and overflow; rd_valid=0 and rx_hold=0 follow combinationally.
REQ-025 Storage contents SHALL not be reset.
REQ-026 Reset asserted mid-operation SHALL discard all buffered words; the first push after deassertion SHALL land in entry 0 and be the first word popped.

Configuration
REQ-027 Macro RXBUF_ALMOST_FULL_EN: defined -> rx_hold=1 when count>=DEPTH-1, giving one cycle of slack for the RX_channel hold-to-stop lag; undefined -> rx_hold=1 only when count==DEPTH. All other behaviour SHALL be identical in both builds.

Structure
REQ-028 Shared package rxbuf_pkg SHALL hold RXBUF_WIDTH_DEF=8, RXBUF_DEPTH_DEF=4 and the count typedef parameterised from depth.
REQ-029 A single sub-module rxbuf_ctrl SHALL own the pointers, count, overflow and rx_hold logic; the storage array SHALL sit in rx_buffer_fifo.

Verification (WIDTH=8, DEPTH=4)
REQ-030 Reset: ARESET pulsed mid-stream with count=3 -> count=0, rd_valid=0, overflow=0 with no clock edge; next push of 0x11 is read first.
REQ-031 Fill/drain: push 0xA1,0xA2,0xA3,0xA4, no rd_en -> count=4, rx_hold=1; then rd_en for 4 cycles -> rd_data 0xA1..0xA4 in order, count=0, rd_valid=0.
REQ-032 Overflow: FULL, rx_new_data with 0x5A and no pop -> 0x5A dropped, count=4, overflow=1 and it stays 1 after draining.
REQ-033 Simultaneous: FULL with push 0x77 and pop -> count=4, oldest word out, 0x77 read last; EMPTY with push 0x33 and rd_en -> count=1, rd_data=0x33 next cycle.
REQ-034 Wrap: 10 push/pop pairs of 0x00..0x09 at count=2 -> pointers wrap, output order preserved, overflow=0.
REQ-035 Macro: build with RXBUF_ALMOST_FULL_EN, count=3 -> rx_hold=1; build without it, count=3 -> rx_hold=0.
